// File: rtl/data_cache_pkg.sv
//==============================================================================
// Module : data_cache_pkg
// Brief  : Shared FSM encoding, address-field widths and block helpers for data_cache.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package data_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WRITE_BACK = 2'd1,
        ST_MEM_READ   = 2'd2,
        ST_UPDATE     = 2'd3
    } dc_state_t;

    localparam int c_addr_w   = 8;
    localparam int c_byte_w   = 8;
    localparam int c_block_w  = 32;
    localparam int c_offset_w = 2;
    localparam int c_index_w  = 3;
    localparam int c_tag_w    = c_addr_w - c_index_w - c_offset_w;

    function automatic logic [c_byte_w-1:0] get_byte(
        input logic [c_block_w-1:0]  blk,
        input logic [c_offset_w-1:0] off
    );
        return blk[{off, 3'b000} +: c_byte_w];
    endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_line_store.sv
//==============================================================================
// Module : dcache_line_store
// Brief  : Valid/dirty/tag/data arrays with a byte-write port and a block-fill port.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module dcache_line_store
    import data_cache_pkg::*;
#(
    parameter int INDEX_W  = c_index_w,
    parameter int OFFSET_W = c_offset_w,
    parameter int TAG_W    = c_tag_w,
    parameter int BLOCK_W  = c_block_w
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [INDEX_W-1:0]  index,
    output logic                valid,
    output logic                dirty,
    output logic [TAG_W-1:0]    tag,
    output logic [BLOCK_W-1:0]  data,
    input  logic                byte_we,
    input  logic [OFFSET_W-1:0] byte_off,
    input  logic [7:0]          byte_data,
    input  logic                fill_we,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [BLOCK_W-1:0]  fill_data
);

    localparam int c_lines = 1 << INDEX_W;

    logic               r_valid [c_lines];
    logic               r_dirty [c_lines];
    logic [TAG_W-1:0]   r_tag   [c_lines];
    logic [BLOCK_W-1:0] r_data  [c_lines];

    assign valid = r_valid[index];
    assign dirty = r_dirty[index];
    assign tag   = r_tag[index];
    assign data  = r_data[index];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < c_lines; i++) begin
                r_valid[i] <= 1'b0;
                r_dirty[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
            end
        end else if (fill_we) begin
            r_valid[index] <= 1'b1;
            r_dirty[index] <= 1'b0;
            r_tag[index]   <= fill_tag;
            r_data[index]  <= fill_data;
        end else if (byte_we) begin
            r_data[index][{byte_off, 3'b000} +: 8] <= byte_data;
            r_dirty[index]                         <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_cache.sv
//==============================================================================
// Module : data_cache
// Brief  : Direct-mapped write-back, write-allocate data cache with block memory port.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module data_cache
    import data_cache_pkg::*;
#(
    parameter int INDEX_W  = c_index_w,
    parameter int OFFSET_W = c_offset_w,
    parameter int TAG_W    = c_addr_w - INDEX_W - OFFSET_W
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           READ,
    input  logic                           WRITE,
    input  logic [c_addr_w-1:0]            ADDRESS,
    input  logic [c_byte_w-1:0]            WRITEDATA,
    output logic [c_byte_w-1:0]            READDATA,
    output logic                           BUSYWAIT,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [c_addr_w-OFFSET_W-1:0]   mem_address,
    output logic [c_block_w-1:0]           mem_writedata,
    input  logic [c_block_w-1:0]           mem_readdata,
    input  logic                           mem_busywait
);

    dc_state_t r_state;
    dc_state_t w_next_state;

    logic [TAG_W-1:0]     w_tag;
    logic [INDEX_W-1:0]   w_idx;
    logic [OFFSET_W-1:0]  w_off;
    logic                 w_line_valid;
    logic                 w_line_dirty;
    logic [TAG_W-1:0]     w_line_tag;
    logic [c_block_w-1:0] w_line_data;
    logic                 w_idle;
    logic                 w_req;
    logic                 w_hit;
    logic                 w_byte_we;
    logic                 w_fill_we;

    assign w_tag = ADDRESS[c_addr_w-1 -: TAG_W];
    assign w_idx = ADDRESS[OFFSET_W +: INDEX_W];
    assign w_off = ADDRESS[OFFSET_W-1:0];

    assign w_idle = (r_state == ST_IDLE);
    assign w_req  = READ | WRITE;
    // Hits only count in IDLE so a line being refilled never answers early.
    assign w_hit  = w_idle & w_line_valid & (w_line_tag == w_tag);

    assign BUSYWAIT  = (w_req & ~w_hit) | ~w_idle;
    assign READDATA  = get_byte(w_line_data, w_off);
    assign w_byte_we = w_hit & WRITE;
    assign w_fill_we = (r_state == ST_UPDATE);

    dcache_line_store #(
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W),
        .TAG_W    (TAG_W),
        .BLOCK_W  (c_block_w)
    ) u_lines (
        .CLK       (CLK),
        .RESET     (RESET),
        .index     (w_idx),
        .valid     (w_line_valid),
        .dirty     (w_line_dirty),
        .tag       (w_line_tag),
        .data      (w_line_data),
        .byte_we   (w_byte_we),
        .byte_off  (w_off),
        .byte_data (WRITEDATA),
        .fill_we   (w_fill_we),
        .fill_tag  (w_tag),
        .fill_data (mem_readdata)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_req && !w_hit) begin
                    w_next_state = w_line_dirty ? ST_WRITE_BACK : ST_MEM_READ;
                end
            end
            ST_WRITE_BACK: begin
                mem_write     = 1'b1;
                mem_address   = {w_line_tag, w_idx};
                mem_writedata = w_line_data;
                if (!mem_busywait) begin
                    w_next_state = ST_MEM_READ;
                end
            end
            ST_MEM_READ: begin
                mem_read    = 1'b1;
                mem_address = {w_tag, w_idx};
                if (!mem_busywait) begin
                    w_next_state = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_data_cache.sv
//==============================================================================
// Module : tb_data_cache
// Brief  : Self-checking bench for data_cache with a 5-cycle-busy block memory model.
// Rev    : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_data_cache;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    data_cache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    // Block memory: byte at address a initially holds a; busy for 5 cycles per request.
    logic [31:0] mem [64];
    logic [2:0]  mem_cnt;
    logic        mem_init;

    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= {8'(i*4+3), 8'(i*4+2), 8'(i*4+1), 8'(i*4)};
            end
            mem_cnt      <= '0;
            mem_readdata <= '0;
        end else if (mem_read || mem_write) begin
            if (mem_cnt == 3'd5) begin
                mem_cnt <= '0;
                if (mem_write) mem[mem_address] <= mem_writedata;
            end else begin
                mem_cnt <= mem_cnt + 3'd1;
            end
            if (mem_read) mem_readdata <= mem[mem_address];
        end else begin
            mem_cnt <= '0;
        end
    end

    assign mem_busywait = (mem_read || mem_write) && (mem_cnt != 3'd5);

    // Bus monitor
    int          rd_cycles = 0;
    int          wr_cycles = 0;
    int          excl_err  = 0;
    int          idle_err  = 0;
    int          order_err = 0;
    logic        prev_rd   = 1'b0;
    logic [5:0]  rd_addr   = '0;
    logic [5:0]  wr_addr   = '0;
    logic [31:0] wr_data   = '0;

    always @(negedge CLK) begin
        #2;
        if (mem_read) begin
            rd_cycles++;
            rd_addr = mem_address;
        end
        if (mem_write) begin
            wr_cycles++;
            wr_addr = mem_address;
            wr_data = mem_writedata;
            if (prev_rd) order_err++;
        end
        if (mem_read && mem_write) excl_err++;
        if (!mem_read && !mem_write && (mem_address != '0 || mem_writedata != '0)) idle_err++;
        prev_rd = mem_read;
    end

    logic [7:0] ref_mem [256];
    logic [7:0] sb_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output int stall);
        #1;
        stall = 0;
        while (BUSYWAIT && stall < 200) begin
            @(negedge CLK);
            #1;
            stall++;
        end
        if (BUSYWAIT) check("busywait_timeout", BUSYWAIT, 0);
    endtask

    task automatic finish_read(input logic [7:0] addr, output int stall);
        wait_ready(stall);
        check($sformatf("readdata@%02h", addr), READDATA, sb_q.pop_front());
        @(negedge CLK);
        READ = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] addr, output int stall);
        @(negedge CLK);
        ADDRESS = addr;
        READ    = 1'b1;
        WRITE   = 1'b0;
        sb_q.push_back(ref_mem[addr]);
        finish_read(addr, stall);
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [7:0] data,
                             input logic also_read, output int stall);
        @(negedge CLK);
        ADDRESS   = addr;
        WRITEDATA = data;
        WRITE     = 1'b1;
        READ      = also_read;
        ref_mem[addr] = data;
        wait_ready(stall);
        @(negedge CLK);
        WRITE = 1'b0;
        READ  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int rd0;
        int wr0;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i);
        RESET     = 1'b1;
        mem_init  = 1'b1;
        READ      = 1'b0;
        WRITE     = 1'b0;
        ADDRESS   = '0;
        WRITEDATA = '0;
        repeat (2) @(negedge CLK);
        mem_init = 1'b0;
        RESET    = 1'b0;

        // Reset state
        @(negedge CLK);
        #1;
        check("rst_busywait", BUSYWAIT, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_readdata", READDATA, 0);
        check("rst_mem_address", mem_address, 0);

        // 1: clean read miss
        rd0 = rd_cycles; wr0 = wr_cycles;
        cpu_read(8'h05, st);
        check("t1_stall", st, 8);
        check("t1_rd_addr", rd_addr, 6'h01);
        check("t1_rd_cycles", rd_cycles - rd0, 6);
        check("t1_no_wb", wr_cycles - wr0, 0);

        // 2: write hit then read hit, no stall, no memory traffic
        rd0 = rd_cycles; wr0 = wr_cycles;
        cpu_write(8'h05, 8'hA7, 1'b0, st);
        check("t2_wr_stall", st, 0);
        cpu_read(8'h05, st);
        check("t2_rd_stall", st, 0);
        check("t2_no_rd", rd_cycles - rd0, 0);
        check("t2_no_wr", wr_cycles - wr0, 0);

        // 3: conflict miss on dirty line -> write-back then fetch
        rd0 = rd_cycles; wr0 = wr_cycles;
        cpu_read(8'h25, st);
        check("t3_stall", st, 14);
        check("t3_wr_addr", wr_addr, 6'h01);
        check("t3_wr_byte1", wr_data[15:8], 8'hA7);
        check("t3_wr_block", wr_data, {ref_mem[7], ref_mem[6], ref_mem[5], ref_mem[4]});
        check("t3_wr_cycles", wr_cycles - wr0, 6);
        check("t3_rd_addr", rd_addr, 6'h09);
        // the written-back byte must come back from memory
        cpu_read(8'h05, st);
        check("t3_refetch_stall", st, 8);

        // 4: write miss on a clean line -> fetch only, then byte merged and dirty
        rd0 = rd_cycles; wr0 = wr_cycles;
        cpu_write(8'h46, 8'h3C, 1'b0, st);
        check("t4_stall", st, 8);
        check("t4_no_wb", wr_cycles - wr0, 0);
        check("t4_rd_addr", rd_addr, 6'h11);
        cpu_read(8'h46, st);
        check("t4_hit_stall", st, 0);
        wr0 = wr_cycles;
        cpu_read(8'h06, st);
        check("t4_dirty_stall", st, 14);
        check("t4_wb_addr", wr_addr, 6'h11);
        check("t4_wb_byte2", wr_data[23:16], 8'h3C);
        check("t4_wb_cycles", wr_cycles - wr0, 6);

        // 5: reset in the third MEM_READ cycle aborts the transfer
        @(negedge CLK);
        ADDRESS = 8'h0C;
        READ    = 1'b1;
        WRITE   = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        check("t5_mr_before_rst", mem_read, 1);
        RESET = 1'b1;
        @(negedge CLK);
        #1;
        check("t5_mr_after_rst", mem_read, 0);
        check("t5_mw_after_rst", mem_write, 0);
        check("t5_busy_in_rst", BUSYWAIT, 1);
        RESET = 1'b0;
        rd0 = rd_cycles;
        sb_q.push_back(ref_mem[8'h0C]);
        finish_read(8'h0C, st);
        check("t5_remiss_stall", st, 8);
        check("t5_remiss_addr", rd_addr, 6'h03);
        check("t5_remiss_cycles", rd_cycles - rd0, 6);
        // every line was invalidated, including index 1
        cpu_read(8'h05, st);
        check("t5_inval_stall", st, 8);

        // 6: READ and WRITE together on a hit act as a write
        cpu_write(8'h0D, 8'h5A, 1'b1, st);
        check("t6_stall", st, 0);
        cpu_read(8'h0D, st);
        check("t6_rd_stall", st, 0);
        wr0 = wr_cycles;
        cpu_read(8'h2C, st);
        check("t6_dirty_stall", st, 14);
        check("t6_wb_addr", wr_addr, 6'h03);
        check("t6_wb_byte1", wr_data[15:8], 8'h5A);

        repeat (2) @(negedge CLK);
        check("bus_exclusive", excl_err, 0);
        check("bus_idle_zero", idle_err, 0);
        check("bus_wb_before_rd", order_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
